// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer_counter block.
// FSM state encoding, bus register offsets, CTRL bit positions and MODE encodings.
package timer_pkg;

   // FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   // MODE field encodings; the two reserved codes run as one-shot
   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'd0,
      MODE_RELOAD  = 2'd1,
      MODE_RSVD2   = 2'd2,
      MODE_RSVD3   = 2'd3
   } mode_e;

   // Register word offsets
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_UNUSED = 2'd3;

   // CTRL layout: only the low CTRL_W bits are stored, the rest read as zero
   localparam int CTRL_W        = 4;
   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM       = 3;

   // True when the MODE field selects periodic reload
   function automatic logic mode_is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter: bus-programmable down-counter with one-shot / auto-reload
// operation and a maskable interrupt line.
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When undefined, MODE 1 runs
// exactly like one-shot (MODE bits are still stored and read back) and the
// reload path is not built.
module timer_counter
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [CNT_W-1:0] wdata,
   output logic [CNT_W-1:0] rdata,
   output logic             irq
);

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [CNT_W-1:0]  preset_q, preset_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              pend_q,   pend_d;

   logic wr_ctrl;
   logic wr_preset;
   logic reload_mode;

   assign wr_ctrl   = we && (addr == ADDR_CTRL);
   assign wr_preset = we && (addr == ADDR_PRESET);

`ifdef TIMER_AUTO_RELOAD_EN
   // Reload decision follows the live MODE field
   assign reload_mode = mode_is_reload(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
`else
   // Reload path absent: every MODE behaves as one-shot
   assign reload_mode = 1'b0;
`endif

   // State and register update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   // Next-state: FSM actions first, bus writes last so a CPU write always
   // overrides the FSM's own CTRL/pending updates in the same cycle.
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               // Disabled mid-count: park with COUNT held
               state_d = ST_IDLE;
            end else if (count_q == '0) begin
               // Raise pending on entry so irq is already high in the INT cycle
               state_d = ST_INT;
               if (!reload_mode) pend_d = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         ST_INT: begin
            if (reload_mode) begin
               state_d = ST_LOAD;
            end else begin
               pend_d          = 1'b1;
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_ctrl) begin
         ctrl_d = wdata[CTRL_W-1:0];
         pend_d = 1'b0;
      end
      if (wr_preset) begin
         preset_d = wdata;
         pend_d   = 1'b0;
      end
   end

   // Combinational register read mux; COUNT writes and offset 3 are ignored
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CTRL:   rdata = {{(CNT_W-CTRL_W){1'b0}}, ctrl_q};
         ADDR_PRESET: rdata = preset_q;
         ADDR_COUNT:  rdata = count_q;
         ADDR_UNUSED: rdata = '0;
         default:     rdata = '0;
      endcase
   end

   // Level irq for one-shot pending; one-cycle pulse per period in reload mode
   assign irq = ctrl_q[CTRL_IM] & (pend_q | ((state_q == ST_INT) & reload_mode));

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of PRESET and COUNT registers and of the bus data path.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port addr  input  2  register select, word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 SHALL have port we  input  1  bus write strobe, sampled on rising clk.
REQ-006 SHALL have port wdata  input  CNT_W  bus write data.
REQ-007 SHALL have port rdata  output  CNT_W  combinational read data for addr.
REQ-008 SHALL have port irq  output  1  interrupt request to the CPU's CP0 hardware-interrupt input.

Function
REQ-009 SHALL decode CTRL fields as: [0] EN count enable, [2:1] MODE (0 one-shot, 1 auto-reload), [3] IM interrupt mask; bits [CNT_W-1:4] SHALL read 0.
REQ-010 SHALL return CTRL, PRESET, COUNT on addr 0/1/2 and 0 on addr 3.
REQ-011 SHALL ignore writes to COUNT and addr 3.
REQ-012 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1 SHALL go to LOAD at next edge; otherwise hold.
REQ-014 LOAD: SHALL set COUNT<=PRESET and go to CNT.
REQ-015 CNT: if EN=0 SHALL go to IDLE with COUNT held; else if COUNT==0 SHALL go to INT; else COUNT<=COUNT-1.
REQ-016 INT, MODE 0: SHALL set pending flag, clear CTRL.EN, and go to IDLE.
REQ-017 INT, MODE 1: SHALL go to LOAD (reload); no pending flag.
REQ-018 irq SHALL equal IM & (pending | (state==INT && MODE==1)); MODE 1 gives a one-cycle pulse per period.
REQ-019 pending SHALL clear on any write to CTRL or PRESET.
REQ-020 Latency: EN written at edge E0 with PRESET=N SHALL give COUNT=N after E2, COUNT=0 after E(N+2), state INT after E(N+3).
REQ-021 PRESET=0 SHALL reach INT one edge after LOAD; no underflow wrap.
REQ-022 Writing PRESET while in CNT SHALL NOT change COUNT until the next LOAD.
REQ-023 A bus write to CTRL in the same cycle that INT (MODE 0) clears EN SHALL win: written CTRL value is kept, pending still clears.
REQ-024 MODE values 2 and 3 SHALL behave as MODE 0.

Reset
REQ-025 reset=0 SHALL immediately force CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0, regardless of clk.
REQ-026 Deassertion mid-operation SHALL resume from IDLE; no count progress is retained.

Configuration
REQ-027 With TIMER_AUTO_RELOAD_EN defined, MODE 1 SHALL behave per REQ-017/018.
REQ-028 Without TIMER_AUTO_RELOAD_EN, MODE 1 SHALL behave exactly as MODE 0, MODE bits SHALL still be stored and read back, and no reload logic SHALL be synthesised.

Structure
REQ-029 Package timer_pkg SHALL hold the FSM state enum, register offset constants, CTRL bit positions and MODE encodings.
REQ-030 Block SHALL be a single module; no sub-module.

Verification
REQ-031 Reset: hold reset=0 mid-count (COUNT=5) -> COUNT=0, state IDLE, irq=0 without a clk edge.
REQ-032 One-shot: PRESET=3, CTRL=0x9 -> COUNT 3,2,1,0; irq=1 from edge E6 and held; CTRL reads 0x8; write PRESET -> irq=0 next cycle.
REQ-033 Auto-reload (macro defined): PRESET=2, CTRL=0xB -> irq one-cycle pulse every 5 cycles, COUNT reloads to 2.
REQ-034 Masked: PRESET=1, CTRL=0x1 -> irq stays 0; pending set; writing CTRL=0x8 -> irq remains 0 (pending cleared).
REQ-035 Edge cases: PRESET=0, CTRL=0x9 -> irq=1 at E3; mid-count PRESET write of 7 -> COUNT unaffected; addr 3 read -> 0.
REQ-036 Macro undefined: CTRL=0xB, PRESET=2 -> single irq held, EN cleared, CTRL reads 0xA.
